std_mshr_file: RTL and testbench



---
 rtl/std_mshr_file.sv | 211 +++++++++++++++++++++
 tb/tb_std_mshr_file.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/std_mshr_file.sv
// ---------------------------------------------------------------------------
// std_mshr_file
// Miss-status holding register file for the non-blocking write-back L1 dcache.
// Tracks up to NumMshr outstanding line misses. Secondary misses to a tracked
// line merge into its entry. Refill requests issue oldest-first through an id
// FIFO, and refills may complete in any order.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   alloc_*                  miss allocation handshake; id/merged are
//                            combinational and meaningful only with valid
//   lookup_addr_i            per-port probe addresses
//   lookup_*_match_o         per-port line / index conflict flags
//   issue_*                  refill request handshake towards the AXI engine
//   done_valid_i, done_id_i  refill completion
//   busy_o, count_o          occupancy
//   err_o                    sticky flag for a completion on a non-inflight id
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module std_mshr_file #(
    parameter int unsigned NumMshr    = 4,
    parameter int unsigned NumPorts   = 4,
    parameter int unsigned AddrWidth  = 56,
    parameter int unsigned IndexWidth = 12,
    parameter int unsigned ByteOffset = 4,
    localparam int unsigned IdW       = (NumMshr > 1) ? $clog2(NumMshr) : 1,
    localparam int unsigned CntW      = $clog2(NumMshr + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                alloc_valid_i,
    output logic                                alloc_ready_o,
    input  logic [AddrWidth-1:0]                alloc_addr_i,
    input  logic                                alloc_we_i,
    output logic [IdW-1:0]                      alloc_id_o,
    output logic                                alloc_merged_o,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  lookup_addr_i,
    output logic [NumPorts-1:0]                 lookup_addr_match_o,
    output logic [NumPorts-1:0]                 lookup_index_match_o,
    output logic                                issue_valid_o,
    input  logic                                issue_ready_i,
    output logic [AddrWidth-1:0]                issue_addr_o,
    output logic [IdW-1:0]                      issue_id_o,
    output logic                                issue_we_o,
    input  logic                                done_valid_i,
    input  logic [IdW-1:0]                      done_id_i,
    output logic                                busy_o,
    output logic [CntW-1:0]                     count_o,
    output logic                                err_o
);

    localparam int unsigned LineW = AddrWidth - ByteOffset;
    localparam int unsigned IdxW  = IndexWidth - ByteOffset;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        PENDING  = 2'd1,
        INFLIGHT = 2'd2
    } entryState_e;

    entryState_e         r_state [NumMshr];
    logic [LineW-1:0]    r_line  [NumMshr];
    logic [NumMshr-1:0]  r_we;
    logic [IdW-1:0]      r_fifo  [NumMshr];
    logic [IdW-1:0]      r_head;
    logic [IdW-1:0]      r_tail;
    logic [CntW-1:0]     r_fifoCnt;
    logic                r_err;

    logic [LineW-1:0]    w_allocLine;
    logic                w_hitAny;
    logic [IdW-1:0]      w_hitId;
    logic                w_freeAny;
    logic [IdW-1:0]      w_freeId;
    logic [CntW-1:0]     w_count;
    logic                w_accept;
    logic                w_doneOk;
    logic                w_issueValid;
    logic                w_issueFire;
    logic [IdW-1:0]      w_headId;
    logic                w_unused;

    assign w_allocLine = alloc_addr_i[AddrWidth-1:ByteOffset];
    assign w_unused    = ^{alloc_addr_i[ByteOffset-1:0], lookup_addr_i};

    function automatic logic [IdW-1:0] nextPtr(input logic [IdW-1:0] ptr);
        return (ptr == IdW'(NumMshr - 1)) ? '0 : ptr + IdW'(1);
    endfunction

    // Scan downwards so the lowest matching index wins. At most one entry
    // can hold a given line, so the hit priority only matters for free slots.
    always_comb begin
        w_hitAny  = 1'b0;
        w_hitId   = '0;
        w_freeAny = 1'b0;
        w_freeId  = '0;
        w_count   = '0;
        for (int e = NumMshr - 1; e >= 0; e--) begin
            if (r_state[e] != FREE && r_line[e] == w_allocLine) begin
                w_hitAny = 1'b1;
                w_hitId  = IdW'(e);
            end
            if (r_state[e] == FREE) begin
                w_freeAny = 1'b1;
                w_freeId  = IdW'(e);
            end else begin
                w_count = w_count + CntW'(1);
            end
        end
    end

    // Only a completion of an INFLIGHT entry is legal; anything else, including
    // an id beyond the table, matches no entry here and is flagged.
    always_comb begin
        w_doneOk = 1'b0;
        for (int e = 0; e < NumMshr; e++) begin
            if (done_valid_i && done_id_i == IdW'(e) && r_state[e] == INFLIGHT) begin
                w_doneOk = 1'b1;
            end
        end
    end

    // A merge is refused when the target is being retired this very cycle,
    // otherwise the secondary miss would land on an entry that is gone.
    assign alloc_ready_o  = w_hitAny ? !(done_valid_i && done_id_i == w_hitId) : w_freeAny;
    assign w_accept       = alloc_valid_i && alloc_ready_o;
    assign alloc_merged_o = alloc_valid_i && w_hitAny;
    assign alloc_id_o     = !alloc_valid_i ? '0 : (w_hitAny ? w_hitId : w_freeId);

    assign w_issueValid = (r_fifoCnt != '0);
    assign w_headId     = r_fifo[r_head];
    assign w_issueFire  = w_issueValid && issue_ready_i;

    assign issue_valid_o = w_issueValid;
    assign issue_id_o    = w_issueValid ? w_headId : '0;
    assign issue_we_o    = w_issueValid && r_we[w_headId];
    assign issue_addr_o  = w_issueValid ? {r_line[w_headId], {ByteOffset{1'b0}}} : '0;

    assign count_o = w_count;
    assign busy_o  = (w_count != '0);
    assign err_o   = r_err;

    // Conflict probes see registered state only, never this cycle's alloc.
    always_comb begin
        lookup_addr_match_o  = '0;
        lookup_index_match_o = '0;
        for (int p = 0; p < NumPorts; p++) begin
            for (int e = 0; e < NumMshr; e++) begin
                if (r_state[e] != FREE) begin
                    if (r_line[e] == lookup_addr_i[p][AddrWidth-1:ByteOffset]) begin
                        lookup_addr_match_o[p] = 1'b1;
                    end
                    if (r_line[e][IdxW-1:0] == lookup_addr_i[p][IndexWidth-1:ByteOffset]) begin
                        lookup_index_match_o[p] = 1'b1;
                    end
                end
            end
        end
    end

    // New allocations only take FREE entries, issue only touches PENDING ones
    // and completion only INFLIGHT ones, so the per-entry updates never collide.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int e = 0; e < NumMshr; e++) begin
                r_state[e] <= FREE;
                r_line[e]  <= '0;
                r_fifo[e]  <= '0;
            end
            r_we      <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_fifoCnt <= '0;
            r_err     <= 1'b0;
        end else begin
            for (int e = 0; e < NumMshr; e++) begin
                if (w_accept && !w_hitAny && w_freeId == IdW'(e)) begin
                    r_state[e] <= PENDING;
                    r_line[e]  <= w_allocLine;
                    r_we[e]    <= alloc_we_i;
                end
                if (w_accept && w_hitAny && w_hitId == IdW'(e)) begin
                    r_we[e] <= r_we[e] | alloc_we_i;
                end
                if (w_issueFire && w_headId == IdW'(e)) begin
                    r_state[e] <= INFLIGHT;
                end
                if (w_doneOk && done_id_i == IdW'(e)) begin
                    r_state[e] <= FREE;
                end
            end
            if (w_accept && !w_hitAny) begin
                r_fifo[r_tail] <= w_freeId;
                r_tail         <= nextPtr(r_tail);
            end
            if (w_issueFire) begin
                r_head <= nextPtr(r_head);
            end
            case ({w_accept && !w_hitAny, w_issueFire})
                2'b10:   r_fifoCnt <= r_fifoCnt + CntW'(1);
                2'b01:   r_fifoCnt <= r_fifoCnt - CntW'(1);
                default: r_fifoCnt <= r_fifoCnt;
            endcase
            if (done_valid_i && !w_doneOk) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_std_mshr_file.sv
`timescale 1ns/1ps

module tb_std_mshr_file;

    // Shared clock and reset for both instances
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Instance A: default geometry, used by the directed scenarios
    logic             aAllocValid;
    logic             aAllocReady;
    logic [55:0]      aAllocAddr;
    logic             aAllocWe;
    logic [1:0]       aAllocId;
    logic             aMerged;
    logic [3:0][55:0] aLookup;
    logic [3:0]       aAddrMatch;
    logic [3:0]       aIdxMatch;
    logic             aIssueValid;
    logic             aIssueReady;
    logic [55:0]      aIssueAddr;
    logic [1:0]       aIssueId;
    logic             aIssueWe;
    logic             aDoneValid;
    logic [1:0]       aDoneId;
    logic             aBusy;
    logic [2:0]       aCount;
    logic             aErr;

    std_mshr_file #(.NumMshr(4), .NumPorts(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .alloc_valid_i(aAllocValid), .alloc_ready_o(aAllocReady),
        .alloc_addr_i(aAllocAddr), .alloc_we_i(aAllocWe),
        .alloc_id_o(aAllocId), .alloc_merged_o(aMerged),
        .lookup_addr_i(aLookup), .lookup_addr_match_o(aAddrMatch),
        .lookup_index_match_o(aIdxMatch),
        .issue_valid_o(aIssueValid), .issue_ready_i(aIssueReady),
        .issue_addr_o(aIssueAddr), .issue_id_o(aIssueId), .issue_we_o(aIssueWe),
        .done_valid_i(aDoneValid), .done_id_i(aDoneId),
        .busy_o(aBusy), .count_o(aCount), .err_o(aErr)
    );

    // Instance R: 8 entries, 2 ports, driven randomly against a model
    logic             rAllocValid;
    logic             rAllocReady;
    logic [55:0]      rAllocAddr;
    logic             rAllocWe;
    logic [2:0]       rAllocId;
    logic             rMerged;
    logic [1:0][55:0] rLookup;
    logic [1:0]       rAddrMatch;
    logic [1:0]       rIdxMatch;
    logic             rIssueValid;
    logic             rIssueReady;
    logic [55:0]      rIssueAddr;
    logic [2:0]       rIssueId;
    logic             rIssueWe;
    logic             rDoneValid;
    logic [2:0]       rDoneId;
    logic             rBusy;
    logic [3:0]       rCount;
    logic             rErr;

    std_mshr_file #(.NumMshr(8), .NumPorts(2)) dutR (
        .clk_i(clk), .rst_i(rst),
        .alloc_valid_i(rAllocValid), .alloc_ready_o(rAllocReady),
        .alloc_addr_i(rAllocAddr), .alloc_we_i(rAllocWe),
        .alloc_id_o(rAllocId), .alloc_merged_o(rMerged),
        .lookup_addr_i(rLookup), .lookup_addr_match_o(rAddrMatch),
        .lookup_index_match_o(rIdxMatch),
        .issue_valid_o(rIssueValid), .issue_ready_i(rIssueReady),
        .issue_addr_o(rIssueAddr), .issue_id_o(rIssueId), .issue_we_o(rIssueWe),
        .done_valid_i(rDoneValid), .done_id_i(rDoneId),
        .busy_o(rBusy), .count_o(rCount), .err_o(rErr)
    );

    // Drives every non-lookup input of instance A in one go
    task automatic applyStimulus(input logic av, input logic [55:0] addr, input logic we,
                                 input logic ir, input logic dv, input logic [1:0] did);
        aAllocValid = av;
        aAllocAddr  = addr;
        aAllocWe    = we;
        aIssueReady = ir;
        aDoneValid  = dv;
        aDoneId     = did;
    endtask

    // Advances to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        compared++; if (aIssueValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_issue_valid got=%0h want=0", aIssueValid); end
        compared++; if (aCount !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_count got=%0d want=0", aCount); end
        compared++; if (aBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got=%0h want=0", aBusy); end
        compared++; if (aErr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err got=%0h want=0", aErr); end
        compared++; if (aAllocReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_alloc_ready got=%0h want=1", aAllocReady); end
        compared++; if (aMerged !== 1'b0 || aAllocId !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_alloc_id got=%0d/%0d want=0/0", aAllocId, aMerged); end
        compared++; if (aAddrMatch !== 4'h0 || aIdxMatch !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_lookup got=%0h/%0h want=0/0", aAddrMatch, aIdxMatch); end
        compared++; if (rCount !== 4'd0 || rIssueValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_r_count got=%0d want=0", rCount); end
        @(negedge clk);
        rst = 1'b0;
        nextCycle();
    endtask

    task automatic test_alloc_basic();
        applyStimulus(1'b1, 56'h1000, 1'b0, 1'b0, 1'b0, 2'd0);
        #1;
        compared++; if (aAllocReady !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_ready got=%0h want=1", aAllocReady); end
        compared++; if (aAllocId !== 2'd0 || aMerged !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_id got=%0d/%0d want=0/0", aAllocId, aMerged); end
        nextCycle();
        applyStimulus(1'b0, 56'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        #1;
        compared++; if (aIssueValid !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_issue_valid got=%0h want=1", aIssueValid); end
        compared++; if (aIssueAddr !== 56'h1000) begin mismatched++; $display("[TB] FAIL basic_issue_addr got=%0h want=1000", aIssueAddr); end
        compared++; if (aIssueId !== 2'd0 || aIssueWe !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_issue_id got=%0d/%0d want=0/0", aIssueId, aIssueWe); end
        compared++; if (aCount !== 3'd1 || aBusy !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_count got=%0d/%0d want=1/1", aCount, aBusy); end
    endtask

    task automatic test_merge_lookup();
        applyStimulus(1'b1, 56'h1008, 1'b1, 1'b0, 1'b0, 2'd0);
        #1;
        compared++; if (aAllocReady !== 1'b1 || aMerged !== 1'b1 || aAllocId !== 2'd0) begin mismatched++; $display("[TB] FAIL merge_alloc got=r%0d m%0d id%0d want=r1 m1 id0", aAllocReady, aMerged, aAllocId); end
        nextCycle();
        applyStimulus(1'b0, 56'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        aLookup[0] = 56'h2000;
        aLookup[1] = 56'h1010;
        aLookup[2] = 56'h100F;
        aLookup[3] = 56'h0;
        #1;
        compared++; if (aIssueWe !== 1'b1) begin mismatched++; $display("[TB] FAIL merge_we got=%0h want=1", aIssueWe); end
        compared++; if (aCount !== 3'd1) begin mismatched++; $display("[TB] FAIL merge_count got=%0d want=1", aCount); end
        compared++; if (aAddrMatch[2:0] !== 3'b100) begin mismatched++; $display("[TB] FAIL lookup_addr got=%0b want=100", aAddrMatch[2:0]); end
        compared++; if (aIdxMatch[2:0] !== 3'b101) begin mismatched++; $display("[TB] FAIL lookup_index got=%0b want=101", aIdxMatch[2:0]); end
        aLookup = '0;
    endtask

    task automatic test_fill_and_order();
        logic [55:0] lines [4];
        lines[0] = 56'h1000; lines[1] = 56'h2040; lines[2] = 56'h3080; lines[3] = 56'h40C0;
        for (int k = 1; k < 4; k++) begin
            applyStimulus(1'b1, lines[k], 1'b0, 1'b0, 1'b0, 2'd0);
            #1;
            compared++; if (aAllocReady !== 1'b1 || aAllocId !== 2'(k) || aMerged !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_alloc%0d got=r%0d id%0d m%0d want=r1 id%0d m0", k, aAllocReady, aAllocId, aMerged, k); end
            nextCycle();
        end
        applyStimulus(1'b1, 56'h5000, 1'b0, 1'b0, 1'b0, 2'd0);
        #1;
        compared++; if (aAllocReady !== 1'b0) begin mismatched++; $display("[TB] FAIL full_ready got=%0h want=0", aAllocReady); end
        compared++; if (aCount !== 3'd4) begin mismatched++; $display("[TB] FAIL full_count got=%0d want=4", aCount); end
        nextCycle();
        compared++; if (aIssueValid !== 1'b1 || aIssueId !== 2'd0) begin mismatched++; $display("[TB] FAIL hold_issue got=v%0d id%0d want=v1 id0", aIssueValid, aIssueId); end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 56'h0, 1'b0, 1'b1, 1'b0, 2'd0);
            #1;
            compared++; if (aIssueValid !== 1'b1 || aIssueId !== 2'(k) || aIssueAddr !== lines[k]) begin mismatched++; $display("[TB] FAIL issue_order%0d got=v%0d id%0d a%0h want=v1 id%0d a%0h", k, aIssueValid, aIssueId, aIssueAddr, k, lines[k]); end
            nextCycle();
        end
        applyStimulus(1'b1, 56'h5000, 1'b0, 1'b0, 1'b1, 2'd2);
        #1;
        compared++; if (aIssueValid !== 1'b0) begin mismatched++; $display("[TB] FAIL issue_drained got=%0h want=0", aIssueValid); end
        compared++; if (aAllocReady !== 1'b0) begin mismatched++; $display("[TB] FAIL same_cycle_free got=%0h want=0", aAllocReady); end
        nextCycle();
        applyStimulus(1'b1, 56'h5000, 1'b0, 1'b0, 1'b0, 2'd0);
        #1;
        compared++; if (aAllocReady !== 1'b1 || aAllocId !== 2'd2 || aMerged !== 1'b0) begin mismatched++; $display("[TB] FAIL reuse_alloc got=r%0d id%0d m%0d want=r1 id2 m0", aAllocReady, aAllocId, aMerged); end
        compared++; if (aCount !== 3'd3) begin mismatched++; $display("[TB] FAIL after_done_count got=%0d want=3", aCount); end
        nextCycle();
        applyStimulus(1'b0, 56'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        #1;
        compared++; if (aCount !== 3'd4 || aIssueId !== 2'd2 || aIssueAddr !== 56'h5000) begin mismatched++; $display("[TB] FAIL reuse_issue got=c%0d id%0d a%0h want=c4 id2 a5000", aCount, aIssueId, aIssueAddr); end
    endtask

    task automatic test_done_race();
        applyStimulus(1'b1, 56'h2040, 1'b0, 1'b0, 1'b1, 2'd1);
        #1;
        compared++; if (aAllocReady !== 1'b0) begin mismatched++; $display("[TB] FAIL race_ready got=%0h want=0", aAllocReady); end
        nextCycle();
        applyStimulus(1'b1, 56'h2040, 1'b0, 1'b0, 1'b0, 2'd0);
        #1;
        compared++; if (aAllocReady !== 1'b1 || aMerged !== 1'b0 || aAllocId !== 2'd1) begin mismatched++; $display("[TB] FAIL race_retry got=r%0d m%0d id%0d want=r1 m0 id1", aAllocReady, aMerged, aAllocId); end
        nextCycle();
        applyStimulus(1'b0, 56'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        #1;
        compared++; if (aCount !== 3'd4 || aErr !== 1'b0) begin mismatched++; $display("[TB] FAIL race_after got=c%0d e%0d want=c4 e0", aCount, aErr); end
    endtask

    task automatic test_error_sticky();
        applyStimulus(1'b0, 56'h0, 1'b0, 1'b0, 1'b1, 2'd1);
        nextCycle();
        applyStimulus(1'b0, 56'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        aLookup[0] = 56'h2040;
        #1;
        compared++; if (aErr !== 1'b1) begin mismatched++; $display("[TB] FAIL err_set got=%0h want=1", aErr); end
        compared++; if (aCount !== 3'd4 || aIssueId !== 2'd2 || aAddrMatch[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL err_state got=c%0d id%0d m%0d want=c4 id2 m1", aCount, aIssueId, aAddrMatch[0]); end
        nextCycle();
        nextCycle();
        compared++; if (aErr !== 1'b1) begin mismatched++; $display("[TB] FAIL err_sticky got=%0h want=1", aErr); end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 56'h7000, 1'b1, 1'b1, 1'b0, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        compared++; if (aCount !== 3'd0 || aBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_count got=c%0d b%0d want=c0 b0", aCount, aBusy); end
        compared++; if (aErr !== 1'b0 || aIssueValid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_flags got=e%0d v%0d want=e0 v0", aErr, aIssueValid); end
        compared++; if (aAllocReady !== 1'b1 || aMerged !== 1'b0 || aAddrMatch !== 4'h0) begin mismatched++; $display("[TB] FAIL midreset_alloc got=r%0d m%0d am%0h want=r1 m0 am0", aAllocReady, aMerged, aAddrMatch); end
        applyStimulus(1'b0, 56'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        aLookup = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nextCycle();
    endtask

    // Model of instance R: which ids hold live lines, which are issued, and
    // the order in which new lines were accepted.
    task automatic test_random();
        bit          mLive [8];
        bit          mInfl [8];
        bit          mWe   [8];
        logic [51:0] mLine [8];
        int          issueQ [$];
        int          inflList [$];
        int          hitId;
        int          freeId;
        int          expCount;
        bit          expReady;
        bit          accepted;
        logic [1:0]  expAm;
        logic [1:0]  expIm;
        logic [51:0] pl;
        int          sel;
        for (int e = 0; e < 8; e++) begin
            mLive[e] = 0; mInfl[e] = 0; mWe[e] = 0; mLine[e] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            sel         = $urandom_range(0, 11);
            rAllocValid = ($urandom_range(0, 2) != 0);
            rAllocAddr  = 56'(sel) * 56'h1040 + 56'($urandom_range(0, 15));
            rAllocWe    = 1'($urandom_range(0, 1));
            rIssueReady = ($urandom_range(0, 1) == 0);
            inflList.delete();
            for (int e = 0; e < 8; e++) if (mInfl[e]) inflList.push_back(e);
            if (inflList.size() > 0 && $urandom_range(0, 2) != 0) begin
                rDoneValid = 1'b1;
                rDoneId    = 3'(inflList[$urandom_range(0, inflList.size() - 1)]);
            end else begin
                rDoneValid = 1'b0;
                rDoneId    = 3'($urandom_range(0, 7));
            end
            for (int p = 0; p < 2; p++) begin
                rLookup[p] = 56'($urandom_range(0, 11)) * 56'h1040 + 56'($urandom_range(0, 15));
            end
            #1;
            hitId = -1; freeId = -1; expCount = 0;
            for (int e = 7; e >= 0; e--) begin
                if (mLive[e] && mLine[e] == rAllocAddr[55:4]) hitId = e;
                if (!mLive[e]) freeId = e;
                if (mLive[e]) expCount++;
            end
            expReady = (hitId >= 0) ? !(rDoneValid && int'(rDoneId) == hitId) : (freeId >= 0);
            accepted = rAllocValid && expReady;
            compared++; if (rAllocReady !== expReady) begin mismatched++; $display("[TB] FAIL rnd_ready cyc%0d got=%0d want=%0d", cyc, rAllocReady, expReady); end
            if (accepted) begin
                compared++; if (rMerged !== (hitId >= 0) || int'(rAllocId) != ((hitId >= 0) ? hitId : freeId)) begin mismatched++; $display("[TB] FAIL rnd_alloc cyc%0d got=id%0d m%0d want=id%0d m%0d", cyc, rAllocId, rMerged, (hitId >= 0) ? hitId : freeId, hitId >= 0); end
                if (hitId < 0) begin
                    compared++; if (mLive[rAllocId]) begin mismatched++; $display("[TB] FAIL rnd_dup_id cyc%0d got=id%0d live want=free id", cyc, rAllocId); end
                end
            end
            compared++; if (rCount !== 4'(expCount) || rBusy !== (expCount != 0)) begin mismatched++; $display("[TB] FAIL rnd_count cyc%0d got=%0d want=%0d", cyc, rCount, expCount); end
            compared++; if (rIssueValid !== (issueQ.size() > 0)) begin mismatched++; $display("[TB] FAIL rnd_issue_valid cyc%0d got=%0d want=%0d", cyc, rIssueValid, issueQ.size() > 0); end
            if (issueQ.size() > 0) begin
                compared++; if (int'(rIssueId) != issueQ[0] || rIssueAddr !== {mLine[issueQ[0]], 4'h0} || rIssueWe !== mWe[issueQ[0]]) begin mismatched++; $display("[TB] FAIL rnd_issue cyc%0d got=id%0d a%0h w%0d want=id%0d a%0h w%0d", cyc, rIssueId, rIssueAddr, rIssueWe, issueQ[0], {mLine[issueQ[0]], 4'h0}, mWe[issueQ[0]]); end
            end
            expAm = '0; expIm = '0;
            for (int p = 0; p < 2; p++) begin
                pl = rLookup[p][55:4];
                for (int e = 0; e < 8; e++) begin
                    if (mLive[e] && mLine[e] == pl) expAm[p] = 1'b1;
                    if (mLive[e] && mLine[e][7:0] == pl[7:0]) expIm[p] = 1'b1;
                end
            end
            compared++; if (rAddrMatch !== expAm || rIdxMatch !== expIm) begin mismatched++; $display("[TB] FAIL rnd_lookup cyc%0d got=%0b/%0b want=%0b/%0b", cyc, rAddrMatch, rIdxMatch, expAm, expIm); end
            // Apply this cycle's events to the model
            if (issueQ.size() > 0 && rIssueReady) begin
                mInfl[issueQ[0]] = 1;
                void'(issueQ.pop_front());
            end
            if (rDoneValid && mInfl[rDoneId]) begin
                mInfl[rDoneId] = 0;
                mLive[rDoneId] = 0;
            end
            if (accepted) begin
                if (hitId >= 0) begin
                    mWe[hitId] = mWe[hitId] | rAllocWe;
                end else begin
                    mLive[freeId] = 1;
                    mInfl[freeId] = 0;
                    mLine[freeId] = rAllocAddr[55:4];
                    mWe[freeId]   = rAllocWe;
                    issueQ.push_back(freeId);
                end
            end
            nextCycle();
        end
        rAllocValid = 1'b0; rIssueReady = 1'b0; rDoneValid = 1'b0;
        #1;
        compared++; if (rErr !== 1'b0) begin mismatched++; $display("[TB] FAIL rnd_err got=%0h want=0", rErr); end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 56'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        aLookup     = '0;
        rAllocValid = 1'b0; rAllocAddr = '0; rAllocWe = 1'b0;
        rIssueReady = 1'b0; rDoneValid = 1'b0; rDoneId = '0;
        rLookup     = '0;
        test_reset();
        test_alloc_basic();
        test_merge_lookup();
        test_fill_and_order();
        test_done_race();
        test_error_sticky();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
